// File: rtl/guess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | guess_pkg : shared types and constants for the number-guessing round logic |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package guess_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_CHECK   = 3'd2,
        S_HOLD    = 3'd3,
        S_ADVANCE = 3'd4,
        S_WIN     = 3'd5,
        S_LOSE    = 3'd6
    } guess_state_t;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_HIGH    = 3'd1,
        RES_LOW     = 3'd2,
        RES_CORRECT = 3'd3,
        RES_BAD     = 3'd4
    } guess_result_t;

    localparam logic [1:0] LEVEL_MAX = 2'd3;
    localparam logic [1:0] ROUND_MAX = 2'd3;

    // Digit positions above the active level do not take part in the compare.
    function automatic logic [3:0] mask_digit(
        input logic [3:0] digit,
        input logic [1:0] pos,
        input logic [1:0] max_digit
    );
        return (pos <= max_digit) ? digit : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd3_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd3_compare : masked 3-digit BCD equality / magnitude / validity compare  |
// | Magnitude compare built only when GUESS_HINT_EN is defined.  Revision 1.0  |
// +----------------------------------------------------------------------------+
module bcd3_compare
    import guess_pkg::*;
(
    input  logic [11:0] guess_bcd,
    input  logic [11:0] target_bcd,
    input  logic [1:0]  max_digit,
    output logic        eq,
    output logic        gt,
    output logic        invalid
);

    logic [11:0] guess_masked;

    for (genvar i = 0; i < 3; i++) begin : g_mask
        assign guess_masked[i*4 +: 4] = mask_digit(guess_bcd[i*4 +: 4], 2'(i + 1), max_digit);
    end

    assign eq      = (guess_masked == target_bcd);
    assign invalid = (guess_masked[3:0] > 4'd9) || (guess_masked[7:4] > 4'd9)
                   || (guess_masked[11:8] > 4'd9);

`ifdef GUESS_HINT_EN
    // Packed valid BCD orders exactly like the decimal value it encodes.
    assign gt = (guess_masked > target_bcd);
`else
    assign gt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/guess_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | guess_round_controller : level/round sequencer and guess judge             |
// | Hint flags driven only when GUESS_HINT_EN is defined.  Revision 1.0        |
// +----------------------------------------------------------------------------+
module guess_round_controller
    import guess_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 7,
    parameter int RESULT_HOLD  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       submit,
    input  logic [3:0] guess_digit_1,
    input  logic [3:0] guess_digit_2,
    input  logic [3:0] guess_digit_3,
    input  logic [3:0] target_digit_1,
    input  logic [3:0] target_digit_2,
    input  logic [3:0] target_digit_3,
    output logic [1:0] max_digit,
    output logic [1:0] round,
    output logic       too_high,
    output logic       too_low,
    output logic       correct,
    output logic       bad_guess,
    output logic [3:0] attempts,
    output logic       win,
    output logic       lose
);

`ifdef GUESS_HINT_EN
    localparam bit HINT_EN = 1'b1;
`else
    localparam bit HINT_EN = 1'b0;
`endif

    localparam int                HOLD_W    = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [3:0]        ATT_LIMIT = 4'(MAX_ATTEMPTS);

    guess_state_t      state_q, state_d;
    logic [1:0]        max_digit_q, max_digit_d;
    logic [1:0]        round_q, round_d;
    logic              too_high_q, too_high_d;
    logic              too_low_q, too_low_d;
    logic              correct_q, correct_d;
    logic              bad_guess_q, bad_guess_d;
    logic [3:0]        attempts_q, attempts_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [11:0]       guess_q, guess_d;

    logic              cmp_eq, cmp_gt, cmp_invalid;
    logic [3:0]        attempts_inc;
    guess_result_t     result;

    bcd3_compare u_compare (
        .guess_bcd  (guess_q),
        .target_bcd ({target_digit_3, target_digit_2, target_digit_1}),
        .max_digit  (max_digit_q),
        .eq         (cmp_eq),
        .gt         (cmp_gt),
        .invalid    (cmp_invalid)
    );

    assign attempts_inc = attempts_q + 4'd1;

    always_comb begin
        result = RES_NONE;
        if (state_q == S_CHECK) begin
            if (cmp_invalid) begin
                result = RES_BAD;
            end else if (cmp_eq) begin
                result = RES_CORRECT;
            end else if (cmp_gt) begin
                result = RES_HIGH;
            end else begin
                result = RES_LOW;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        max_digit_d = max_digit_q;
        round_d     = round_q;
        too_high_d  = too_high_q;
        too_low_d   = too_low_q;
        correct_d   = correct_q;
        bad_guess_d = bad_guess_q;
        attempts_d  = attempts_q;
        win_d       = win_q;
        lose_d      = lose_q;
        hold_cnt_d  = hold_cnt_q;
        guess_d     = guess_q;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d     = S_PLAY;
                    max_digit_d = 2'd1;
                    round_d     = 2'd1;
                    too_high_d  = 1'b0;
                    too_low_d   = 1'b0;
                    correct_d   = 1'b0;
                    bad_guess_d = 1'b0;
                    attempts_d  = 4'd0;
                    win_d       = 1'b0;
                    lose_d      = 1'b0;
                    hold_cnt_d  = '0;
                    guess_d     = '0;
                end
            end

            S_PLAY: begin
                if (submit) begin
                    guess_d = {guess_digit_3, guess_digit_2, guess_digit_1};
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                too_high_d  = 1'b0;
                too_low_d   = 1'b0;
                correct_d   = 1'b0;
                bad_guess_d = 1'b0;
                case (result)
                    RES_BAD: begin
                        bad_guess_d = 1'b1;
                        state_d     = S_PLAY;
                    end
                    RES_CORRECT: begin
                        correct_d  = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end
                    default: begin
                        too_high_d = HINT_EN && (result == RES_HIGH);
                        too_low_d  = HINT_EN && (result == RES_LOW);
                        attempts_d = attempts_inc;
                        if (attempts_inc == ATT_LIMIT) begin
                            lose_d  = 1'b1;
                            state_d = S_LOSE;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end
                endcase
            end

            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = S_ADVANCE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end

            S_ADVANCE: begin
                too_high_d  = 1'b0;
                too_low_d   = 1'b0;
                correct_d   = 1'b0;
                bad_guess_d = 1'b0;
                attempts_d  = 4'd0;
                state_d     = S_PLAY;
                if (round_q < ROUND_MAX) begin
                    round_d = round_q + 2'd1;
                end else if (max_digit_q < LEVEL_MAX) begin
                    max_digit_d = max_digit_q + 2'd1;
                    round_d     = 2'd1;
                end else begin
                    win_d   = 1'b1;
                    state_d = S_WIN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            max_digit_q <= 2'd1;
            round_q     <= 2'd1;
            too_high_q  <= 1'b0;
            too_low_q   <= 1'b0;
            correct_q   <= 1'b0;
            bad_guess_q <= 1'b0;
            attempts_q  <= 4'd0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            hold_cnt_q  <= '0;
            guess_q     <= '0;
        end else begin
            state_q     <= state_d;
            max_digit_q <= max_digit_d;
            round_q     <= round_d;
            too_high_q  <= too_high_d;
            too_low_q   <= too_low_d;
            correct_q   <= correct_d;
            bad_guess_q <= bad_guess_d;
            attempts_q  <= attempts_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            hold_cnt_q  <= hold_cnt_d;
            guess_q     <= guess_d;
        end
    end

    assign max_digit = max_digit_q;
    assign round     = round_q;
    assign too_high  = too_high_q;
    assign too_low   = too_low_q;
    assign correct   = correct_q;
    assign bad_guess = bad_guess_q;
    assign attempts  = attempts_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_guess_round_controller : randomized bench with game-rule reference model |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_guess_round_controller;

    localparam int MAXA = 3;
    localparam int HOLD = 3;
`ifdef GUESS_HINT_EN
    localparam int HINT = 1;
`else
    localparam int HINT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, start, submit;
    logic [3:0] guess_digit_1, guess_digit_2, guess_digit_3;
    logic [3:0] target_digit_1, target_digit_2, target_digit_3;
    logic [1:0] max_digit, round;
    logic       too_high, too_low, correct, bad_guess, win, lose;
    logic [3:0] attempts;

    int n_checks = 0;
    int n_fail   = 0;
    int tgt[9];
    int tidx;

    guess_round_controller #(.MAX_ATTEMPTS(MAXA), .RESULT_HOLD(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .submit(submit),
        .guess_digit_1(guess_digit_1), .guess_digit_2(guess_digit_2), .guess_digit_3(guess_digit_3),
        .target_digit_1(target_digit_1), .target_digit_2(target_digit_2), .target_digit_3(target_digit_3),
        .max_digit(max_digit), .round(round), .too_high(too_high), .too_low(too_low),
        .correct(correct), .bad_guess(bad_guess), .attempts(attempts), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Target lookup table addressed by the design's selects.
    always @* begin
        tidx = (int'(max_digit) - 1) * 3 + int'(round) - 1;
        if (tidx < 0 || tidx > 8) tidx = 0;
        target_digit_1 = 4'(tgt[tidx] % 10);
        target_digit_2 = 4'((tgt[tidx] / 10) % 10);
        target_digit_3 = 4'(tgt[tidx] / 100);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules with event timestamps instead of states.
    int m_level = 1, m_round = 1, m_att = 0;
    int m_hi = 0, m_lo = 0, m_ok = 0, m_bad = 0, m_win = 0, m_lose = 0;
    int cyc = 0, judge_at = -1, adv_at = -1, playing = 0, m_next;
    int cap[3];

    task automatic model_init();
        m_level = 1; m_round = 1; m_att = 0;
        m_hi = 0; m_lo = 0; m_ok = 0; m_bad = 0; m_win = 0; m_lose = 0;
    endtask

    function automatic int cur_target();
        return tgt[(m_level - 1) * 3 + m_round - 1];
    endfunction

    task automatic model_judge();
        int gv, bad, tv;
        gv = 0; bad = 0; tv = cur_target();
        for (int p = 0; p < 3; p++) begin
            if (p < m_level) begin
                if (cap[p] > 9) bad = 1;
                gv += cap[p] * ((p == 0) ? 1 : (p == 1) ? 10 : 100);
            end
        end
        m_hi = 0; m_lo = 0; m_ok = 0; m_bad = 0;
        if (bad != 0) begin
            m_bad = 1; playing = 1;
        end else if (gv == tv) begin
            m_ok = 1; adv_at = cyc + HOLD + 1;
        end else begin
            m_hi = (gv > tv && HINT != 0) ? 1 : 0;
            m_lo = (gv < tv && HINT != 0) ? 1 : 0;
            m_att++;
            if (m_att == MAXA) m_lose = 1; else playing = 1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            model_init(); playing = 0; judge_at = -1; adv_at = -1;
        end else if (adv_at == cyc) begin
            adv_at = -1;
            m_hi = 0; m_lo = 0; m_ok = 0; m_bad = 0; m_att = 0;
            m_next = (m_level - 1) * 3 + m_round;
            if (m_next == 9) m_win = 1;
            else begin
                m_level = m_next / 3 + 1; m_round = m_next % 3 + 1; playing = 1;
            end
        end else if (judge_at == cyc) begin
            judge_at = -1;
            model_judge();
        end else if (playing != 0 && submit) begin
            cap[0] = int'(guess_digit_1); cap[1] = int'(guess_digit_2); cap[2] = int'(guess_digit_3);
            judge_at = cyc + 1; playing = 0;
        end else if (playing == 0 && judge_at < 0 && adv_at < 0 && start) begin
            model_init(); playing = 1;
        end
    end

    always @(posedge clk) begin
        #2;
        check("max_digit", max_digit, m_level);
        check("round", round, m_round);
        check("too_high", too_high, m_hi);
        check("too_low", too_low, m_lo);
        check("correct", correct, m_ok);
        check("bad_guess", bad_guess, m_bad);
        check("attempts", attempts, m_att);
        check("win", win, m_win);
        check("lose", lose, m_lose);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_noise(input int n);
        for (int i = 0; i < n; i++) begin
            submit = ($urandom_range(0, 2) == 0);
            start  = ($urandom_range(0, 3) == 0);
            guess_digit_1 = 4'($urandom_range(0, 15));
            guess_digit_2 = 4'($urandom_range(0, 15));
            guess_digit_3 = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        submit = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic submit_guess(input int d3, input int d2, input int d1);
        guess_digit_3 = 4'(d3); guess_digit_2 = 4'(d2); guess_digit_1 = 4'(d1);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        guess_digit_1 = 4'($urandom_range(0, 15));
        guess_digit_2 = 4'($urandom_range(0, 15));
        guess_digit_3 = 4'($urandom_range(0, 15));
    endtask

    // Masked positions get arbitrary garbage, including non-BCD codes.
    task automatic submit_value(input int v);
        int d2, d3;
        d2 = (m_level >= 2) ? (v / 10) % 10 : $urandom_range(0, 15);
        d3 = (m_level >= 3) ? v / 100 : $urandom_range(0, 15);
        submit_guess(d3, d2, v % 10);
    endtask

    task automatic submit_wrong();
        int span;
        span = (m_level == 1) ? 10 : (m_level == 2) ? 100 : 1000;
        submit_value((cur_target() + 1 + $urandom_range(0, span - 2)) % span);
    endtask

    task automatic play_correct();
        submit_value(cur_target());
        tick_noise(1);
        check("correct_seen", correct, 1);
        tick_noise(HOLD + 1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; submit = 1'b0;
        guess_digit_1 = 4'd0; guess_digit_2 = 4'd0; guess_digit_3 = 4'd0;
        tgt[0] = 2; tgt[1] = 8; tgt[2] = $urandom_range(1, 9);
        for (int i = 3; i < 6; i++) tgt[i] = $urandom_range(10, 99);
        tgt[6] = $urandom_range(100, 998); tgt[7] = $urandom_range(100, 998); tgt[8] = 999;
        repeat (3) @(negedge clk);
        check("rst_max_digit", max_digit, 1);
        check("rst_round", round, 1);
        check("rst_flags", {too_high, too_low, correct, bad_guess, win, lose}, 0);
        check("rst_attempts", attempts, 0);
        reset_n = 1'b1;
        tick(1);
        pulse_start();

        submit_guess(0, 0, 2); tick(1);
        check("first_correct", correct, 1);
        tick(HOLD + 1);
        check("adv_round", round, 2);
        check("adv_level", max_digit, 1);

        submit_guess(0, 0, 5); tick(1);
        check("low_5_vs_8", too_low, HINT);
        submit_guess(0, 0, 9); tick(1);
        check("high_9_vs_8", too_high, HINT);
        check("attempts_two", attempts, 2);
        play_correct();

        submit_guess(4'hA, 0, 0); tick(1);
        check("masked_digit_ok", bad_guess, 0);
        submit_guess(0, 0, 4'hC); tick(1);
        check("bad_digit", bad_guess, 1);
        check("bad_keeps_attempts", attempts, 1);
        play_correct();

        for (int r = 3; r < 9; r++) begin
            repeat ($urandom_range(0, MAXA - 1)) begin
                submit_wrong(); tick_noise(1);
            end
            play_correct();
        end
        check("win_flag", win, 1);
        check("win_level", max_digit, 3);
        check("win_round", round, 3);
        submit_value(999); tick(2);
        check("win_held", win, 1);
        pulse_start();
        check("restart_round", round, 1);
        check("restart_level", max_digit, 1);

        submit_guess(0, 0, 5); tick(1);
        submit_guess(0, 0, 0); tick(1);
        submit_guess(0, 0, 7); tick(1);
        check("lose_flag", lose, 1);
        check("lose_attempts", attempts, 3);
        submit_guess(0, 0, 2); tick(2);
        check("lose_ignores_submit", correct, 0);
        pulse_start();
        check("relose_round", round, 1);
        check("relose_lose", lose, 0);

        submit_guess(0, 0, 2); tick(1); tick(HOLD + 1);
        submit_guess(0, 0, 8); tick(2);
        check("hold_round", round, 2);
        reset_n = 1'b0; #1;
        check("async_rst_round", round, 1);
        check("async_rst_correct", correct, 0);
        @(negedge clk); reset_n = 1'b1;
        tick(2);
        pulse_start();

        for (int c = 0; c < 500; c++) begin
            start  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) submit_value(cur_target());
            else if ($urandom_range(0, 1) == 0) submit_guess($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
            else tick(1);
            start = 1'b0;
            if (c == 250) begin
                reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
            end
        end
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/guess_round_controller.md
# guess_round_controller

Sequencer and judge for the number-guessing game. It drives the level (`max_digit`) and round selects into the target-number lookup and reads back the three BCD target digits. It registers and compares each submitted player guess against the target, and reports too-high, too-low or correct. It advances rounds and levels on correct guesses and ends the game in WIN or LOSE.

## Interface
Parameters:
- `MAX_ATTEMPTS`, default 7: wrong guesses allowed per round before LOSE (1..15).
- `RESULT_HOLD`, default 50_000_000: cycles a correct result is held before advancing (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse; begins a new game from IDLE, WIN or LOSE.
- `submit` input 1: one-cycle pulse (already debounced); player commits the guess.
- `guess_digit_1`, `guess_digit_2`, `guess_digit_3` input 4 each: guess BCD digits, where `_1` is the ones digit.
- `target_digit_1`, `target_digit_2`, `target_digit_3` input 4 each: digits returned by the target lookup.
- `max_digit` output 2: level select to the lookup (1..3).
- `round` output 2: round select to the lookup (1..3).
- `too_high`, `too_low`, `correct` output 1 each: result of the last guess; one-hot or all zero.
- `bad_guess` output 1: last submission contained a digit >9.
- `attempts` output 4: wrong guesses in the current round.
- `win`, `lose` output 1 each: terminal status.

## Operation
States: IDLE, PLAY, CHECK, HOLD, ADVANCE, WIN, LOSE.
- **IDLE:**
  - `max_digit`=1 and `round`=1.
  - On `start`, go to PLAY.
- **PLAY:** on `submit`, capture the guess digits into a register and go to CHECK.
- **Digit masking:** guess digits at positions above `max_digit` are forced to 0 before compare. For example, at level 1 only `guess_digit_1` counts.
- **CHECK** (one cycle): compare the masked captured guess against the target as a 3-digit decimal magnitude.
  - Any captured unmasked digit >9: set `bad_guess`, clear the three result flags, leave `attempts` unchanged, go to PLAY.
  - Equal: set `correct`, go to HOLD.
  - Guess greater than target: set `too_high`.
  - Guess less than target: set `too_low`.
  - On a too-high or too-low result, `attempts`+1. If the new value equals `MAX_ATTEMPTS`, go to LOSE; otherwise go to PLAY.
- **HOLD:** count `RESULT_HOLD` cycles, then go to ADVANCE. `submit` is ignored in HOLD.
- **ADVANCE** (one cycle):
  - Clear the result flags and `attempts`.
  - If `round`<3: `round`+1.
  - Else if `max_digit`<3: `max_digit`+1 and `round`=1.
  - Else: go to WIN.
  - Otherwise go to PLAY.
- **WIN and LOSE:** flag held. `max_digit` and `round` hold their last values. On `start`, perform a full re-init (as after reset) and go to PLAY.
- **`start` mid-game:** ignored in PLAY, CHECK, HOLD and ADVANCE.
- **`submit` outside PLAY:** dropped, not queued.
- **`submit` and `start` in the same cycle:** only the input meaningful in the current state is honoured.

## Timing
- Reset values:
  - state IDLE
  - `max_digit`=1, `round`=1
  - all flags 0, `attempts`=0
  - hold counter 0
- All outputs are registered.
- Lookup selects change only in ADVANCE, so the target is stable from PLAY through CHECK.
- `submit` in cycle N: guess captured at edge N+1, result flags and `attempts` valid after edge N+2.
- Correct guess: selects update `RESULT_HOLD`+2 cycles after the CHECK edge.
- Reset asserted mid-operation returns to IDLE immediately. The hold counter and captured guess are cleared.
- `attempts` never wraps, because LOSE is entered on reaching `MAX_ATTEMPTS`.

## Configuration
- `GUESS_HINT_EN` defined: `too_high` and `too_low` are driven as above.
- Undefined:
  - `too_high` and `too_low` are tied to 0.
  - The magnitude comparator is not built; only equality is tested.
  - A wrong guess still increments `attempts`.

## Structure
- Shared package `guess_pkg`:
  - state enum `guess_state_t`
  - result enum (NONE, HIGH, LOW, CORRECT, BAD)
  - constants `LEVEL_MAX`=3 and `ROUND_MAX`=3
- Sub-module `bcd3_compare`: combinational. Inputs are two 3-digit BCD values plus `max_digit` for masking. Outputs are `eq`, `gt` and `invalid`.

## Test plan
- Reset, then `start`, then `submit` guess 0,0,2 with target 0,0,2 → `correct`=1 after 2 cycles. After HOLD, `round`=2 and `max_digit`=1.
- Level 1 with target 8: submit 5, then 9 → `too_low` then `too_high`, `attempts`=2.
- `MAX_ATTEMPTS`=3: three wrong guesses → `lose`=1 and `attempts`=3. Further `submit` has no effect. `start` restores level 1, round 1.
- Guess digits (0xA, 0, 0) at level 1 → not `bad_guess`, because the digit is masked. Digit 1 = 0xC → `bad_guess`=1 and `attempts` unchanged.
- Play all nine rounds correctly (final target 9,9,9) → `win`=1, `max_digit`=3, `round`=3.
- Assert `reset_n` low during HOLD → all outputs at reset values on the next edge, state IDLE. Repeat with `GUESS_HINT_EN` undefined: wrong guesses leave `too_high` and `too_low` at 0.
